// File: rtl/ssd_scan_driver_if.sv
// Display-side bundle for ssd_scan_driver.
// master = game/state logic, slave = the scan driver itself.
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;

  modport master (
    output value,
    output dp_in,
    output blank_in,
    output load,
    input  seg,
    input  dp,
    input  an,
    input  frame_done
  );

  modport slave (
    input  value,
    input  dp_in,
    input  blank_in,
    input  load,
    output seg,
    output dp,
    output an,
    output frame_done
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed 7-segment scan driver, double-buffered on frame edges.
// Optional: SSD_LEADING_ZERO_BLANK_EN auto-blanks leading zero digits.
module ssd_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input logic clk,
  input logic reset,
  ssd_scan_driver_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL = (ACTIVE_LOW != 0);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] val;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blk;
  } buf_t;

  logic [CW-1:0]         div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  buf_t                  sh_q, sh_d;
  buf_t                  disp_q, disp_d;
  buf_t                  live;
  logic                  pend_q, pend_d;
  logic                  fd_q, fd_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  tc, fb;
  logic [3:0]            nib;
  logic                  blk_sel, dp_sel, lz_sel;
  logic [NUM_DIGITS-1:0] lz;
  logic [NUM_DIGITS-1:0] onehot;

  function automatic logic [6:0] dec(
    input logic [3:0] n
  );
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign live.val = bus.value;
  assign live.dp  = bus.dp_in;
  assign live.blk = bus.blank_in;

  assign tc = (div_q == CW'(REFRESH_DIV - 1));
  assign fb = tc && (idx_q == IW'(NUM_DIGITS - 1));

  always_comb begin
    div_d = tc ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (tc) begin
      idx_d = fb ? '0 : idx_q + 1'b1;
    end
    fd_d = fb;
  end

  // A load landing on the frame edge bypasses the shadow entirely.
  always_comb begin
    sh_d   = sh_q;
    disp_d = disp_q;
    pend_d = pend_q;
    if (bus.load) begin
      sh_d   = live;
      pend_d = 1'b1;
    end
    if (fb) begin
      if (bus.load) begin
        disp_d = live;
        pend_d = 1'b0;
      end else if (pend_q) begin
        disp_d = sh_q;
        pend_d = 1'b0;
      end
    end
  end

  always_comb begin
    lz = '0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
    begin
      logic zab;
      zab = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        zab = zab &
          (disp_q.val[4*i +: 4] == 4'h0);
        lz[i] = zab;
      end
    end
`endif
  end

  always_comb begin
    nib     = 4'h0;
    blk_sel = 1'b0;
    dp_sel  = 1'b0;
    lz_sel  = 1'b0;
    onehot  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib       = disp_q.val[4*i +: 4];
        blk_sel   = disp_q.blk[i];
        dp_sel    = disp_q.dp[i];
        lz_sel    = lz[i];
        onehot[i] = 1'b1;
      end
    end
  end

  // Auto-blank hides the glyph only; the dp survives.
  always_comb begin
    seg_d = dec(nib);
    if (blk_sel || lz_sel) begin
      seg_d = 7'h00;
    end
    dp_d = dp_sel && !blk_sel;
    seg_d = seg_d ^ {7{POL}};
    dp_d  = dp_d ^ POL;
    an_d  = onehot ^ {NUM_DIGITS{POL}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      disp_q <= '0;
      pend_q <= 1'b0;
      fd_q   <= 1'b0;
      seg_q  <= {7{POL}};
      dp_q   <= POL;
      an_q   <= {NUM_DIGITS{POL}};
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      fd_q   <= fd_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver, 4 digits, divide-by-4,
// active-low outputs.
module tb_ssd_scan_driver;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec = 0;
  int   miss = 0;

`ifdef SSD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z = 7'h7F;
`else
  localparam logic [6:0] Z = 7'h40;
`endif

  ssd_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  ssd_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .ACTIVE_LOW (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %0h want %0h",
        tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " an"}, 32'(bus.an), 32'hF);
    chk({tag, " seg"}, 32'(bus.seg), 32'h7F);
    chk({tag, " dp"}, 32'(bus.dp), 32'h1);
    chk({tag, " fd"}, 32'(bus.frame_done), 32'h0);
  endtask

  task automatic load_pulse(
    input logic [15:0] v,
    input logic [3:0]  d,
    input logic [3:0]  b
  );
    bus.value    = v;
    bus.dp_in    = d;
    bus.blank_in = b;
    bus.load     = 1'b1;
    tick;
    bus.load     = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    chk({tag, " wait_fd"},
      32'(bus.frame_done), 32'h1);
  endtask

  task automatic show_frame(
    input string       tag,
    input logic [27:0] segs,
    input logic [3:0]  dps
  );
    logic [3:0] an_e;
    for (int d = 0; d < 4; d++) begin
      an_e = ~(4'b0001 << d);
      for (int c = 0; c < 4; c++) begin
        tick;
        if (c == 0 || c == 3) begin
          chk($sformatf("%s an d%0d c%0d", tag, d, c),
            32'(bus.an), 32'(an_e));
          chk($sformatf("%s seg d%0d c%0d", tag, d, c),
            32'(bus.seg), 32'(segs[7*d +: 7]));
          chk($sformatf("%s dp d%0d c%0d", tag, d, c),
            32'(bus.dp), 32'(dps[d]));
        end
        if (c == 0) begin
          chk($sformatf("%s fd0 d%0d", tag, d),
            32'(bus.frame_done), 32'h0);
        end
      end
    end
    chk({tag, " fd1"}, 32'(bus.frame_done), 32'h1);
  endtask

  initial begin
    bus.value    = 16'h0;
    bus.dp_in    = 4'h0;
    bus.blank_in = 4'h0;
    bus.load     = 1'b0;

    // reset state, then release and scan a bit
    tick;
    tick;
    chk_idle("rst");
    reset = 1'b0;
    tick;
    chk("rel an", 32'(bus.an), 32'hE);
    chk("rel seg", 32'(bus.seg), 32'h40);
    repeat (5) tick;

    // pending load is lost on a mid-frame reset
    load_pulse(16'h3333, 4'h0, 4'h0);
    tick;
    reset = 1'b1;
    #1;
    chk_idle("midrst");
    tick;
    chk_idle("midrst hold");
    reset = 1'b0;
    tick;
    chk("rst2 an", 32'(bus.an), 32'hE);
    chk("rst2 seg", 32'(bus.seg), 32'h40);
    wait_fd("rst2");
    show_frame("zero", {Z, Z, Z, 7'h40}, 4'b1111);

    // 12AF with dp on digit 2, two frames
    load_pulse(16'h12AF, 4'b0100, 4'h0);
    wait_fd("12AF");
    show_frame("12AF a",
      {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011);
    show_frame("12AF b",
      {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011);

    // two loads in one frame: only the last lands
    load_pulse(16'h1111, 4'h0, 4'h0);
    load_pulse(16'h2222, 4'h0, 4'h0);
    tick;
    tick;
    chk("hold d0 seg", 32'(bus.seg), 32'h0E);
    tick;
    chk("hold d1 an", 32'(bus.an), 32'hD);
    chk("hold d1 seg", 32'(bus.seg), 32'h08);
    chk("hold d1 dp", 32'(bus.dp), 32'h1);
    wait_fd("2222");
    show_frame("2222",
      {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);

    // load coinciding with the frame boundary
    repeat (15) tick;
    bus.value    = 16'h00C0;
    bus.dp_in    = 4'h0;
    bus.blank_in = 4'h0;
    bus.load     = 1'b1;
    tick;
    bus.load     = 1'b0;
    chk("fbload fd", 32'(bus.frame_done), 32'h1);
    show_frame("00C0 a", {Z, Z, 7'h46, 7'h40}, 4'b1111);
    show_frame("00C0 b", {Z, Z, 7'h46, 7'h40}, 4'b1111);

    // explicit blanking of digit 3
    load_pulse(16'h8888, 4'h0, 4'b1000);
    wait_fd("8888");
    show_frame("8888",
      {7'h7F, 7'h00, 7'h00, 7'h00}, 4'b1111);

    // leading-zero handling
    load_pulse(16'h0050, 4'h0, 4'h0);
    wait_fd("0050");
    show_frame("0050", {Z, Z, 7'h12, 7'h40}, 4'b1111);
    load_pulse(16'h0000, 4'b1000, 4'h0);
    wait_fd("0000");
    show_frame("0000", {Z, Z, Z, 7'h40}, 4'b0111);

    $display("== %0d vectors applied, %0d miscompares ==",
      vec, miss);
    $finish;
  end

endmodule
